// File: rtl/spi_link_slave_mc_if.sv
// spi_link_slave_mc_if: SPI pins plus the parallel frame-side signals of the link slave
interface spi_link_slave_mc_if #(
    parameter int N_CH = 2,
    parameter int W    = 32
);
    logic              en;
    logic              sck;
    logic              ssel;
    logic              mosi;
    logic              miso;
    logic [N_CH*W-1:0] tx_data;
    logic [N_CH*W-1:0] rx_data;
    logic              rx_valid;
    logic              frame_err;
    logic              busy;
    logic [15:0]       frame_cnt;

    modport master (
        output en, sck, ssel, mosi, tx_data,
        input  miso, rx_data, rx_valid, frame_err, busy, frame_cnt
    );

    modport slave (
        input  en, sck, ssel, mosi, tx_data,
        output miso, rx_data, rx_valid, frame_err, busy, frame_cnt
    );
endinterface

// File: rtl/spi_link_slave_mc.sv
// spi_link_slave_mc: oversampled SPI mode-0 slave exchanging N_CH words of W bits per frame
module spi_link_slave_mc #(
    parameter int N_CH = 2,
    parameter int W    = 32,
    parameter int SYNC = 3
) (
    input  logic              clk,
    input  logic              reset_global,
    spi_link_slave_mc_if.slave bus
);
    localparam int NB = N_CH * W;
    localparam int CW = $clog2(NB + 1);
    localparam logic [CW-1:0] NB_C = CW'(NB);

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

    state_t          state, state_nx;
    logic [SYNC-1:0] sck_q, ssel_q, mosi_q;
    logic [NB-1:0]   tx_sh, rx_sh, tx_stream, rx_word, rx_data_q;
    logic [CW-1:0]   bit_cnt;
    logic            ovf;
    logic [15:0]     frame_cnt_q;
    logic            sck_rise, sck_fall, ssel_rise, ssel_fall, start, good;

    // shadows hold the frame in wire order (channel 0 MSB first at the top); map to channel layout
    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        assign tx_stream[NB-1-k*W -: W] = bus.tx_data[k*W +: W];
        assign rx_word[k*W +: W]        = rx_sh[NB-1-k*W -: W];
    end

    assign sck_rise  =  sck_q[SYNC-2]  & ~sck_q[SYNC-1];
    assign sck_fall  = ~sck_q[SYNC-2]  &  sck_q[SYNC-1];
    assign ssel_rise =  ssel_q[SYNC-2] & ~ssel_q[SYNC-1];
    assign ssel_fall = ~ssel_q[SYNC-2] &  ssel_q[SYNC-1];
    assign start     = (state == IDLE) && ssel_fall && bus.en;
    assign good      = (bit_cnt == NB_C) && !ovf;

    assign bus.rx_data   = rx_data_q;
    assign bus.frame_cnt = frame_cnt_q;

    // pin synchronisers; ssel resets low so a select held across reset never looks like a new frame
    always_ff @(posedge clk or posedge reset_global)
        if (reset_global) begin
            sck_q  <= '0;
            ssel_q <= '0;
            mosi_q <= '0;
        end else begin
            sck_q  <= {sck_q[SYNC-2:0], bus.sck};
            ssel_q <= {ssel_q[SYNC-2:0], bus.ssel};
            mosi_q <= {mosi_q[SYNC-2:0], bus.mosi};
        end

    // frame state register
    always_ff @(posedge clk or posedge reset_global)
        if (reset_global) state <= IDLE;
        else              state <= state_nx;

    // next state and frame-level outputs; sck work in the ssel-rise cycle lands before CHECK decides
    always_comb begin
        state_nx      = state;
        bus.rx_valid  = 1'b0;
        bus.frame_err = 1'b0;
        bus.busy      = state != IDLE;
        bus.miso      = (state == SHIFT) ? tx_sh[NB-1] : 1'b0;
        unique case (state)
            IDLE:    state_nx = start ? SHIFT : IDLE;
            SHIFT:   state_nx = ssel_rise ? CHECK : SHIFT;
            CHECK: begin
                state_nx      = IDLE;
                bus.rx_valid  = good;
                bus.frame_err = !good;
            end
            default: state_nx = IDLE;
        endcase
    end

    // shift datapath, bit counting with overflow latch, and commit of good frames
    always_ff @(posedge clk or posedge reset_global)
        if (reset_global) begin
            tx_sh       <= '0;
            rx_sh       <= '0;
            bit_cnt     <= '0;
            ovf         <= 1'b0;
            rx_data_q   <= '0;
            frame_cnt_q <= '0;
        end else begin
            if (start) begin
                tx_sh   <= tx_stream;
                bit_cnt <= '0;
                ovf     <= 1'b0;
            end
            if (state == SHIFT && sck_rise) begin
                if (bit_cnt == NB_C) ovf <= 1'b1;
                else begin
                    rx_sh   <= {rx_sh[NB-2:0], mosi_q[SYNC-1]};
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
            if (state == SHIFT && sck_fall) tx_sh <= {tx_sh[NB-2:0], 1'b0};
            if (state == CHECK && good) begin
                rx_data_q   <= rx_word;
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
endmodule

// File: tb/tb_spi_link_slave_mc.sv
// tb_spi_link_slave_mc: table-driven SPI frames with a scoreboard of expected rx_valid/frame_err results
module tb_spi_link_slave_mc;
    typedef struct {
        logic         en;
        int           nbits;
        int           rst_at;
        logic         mid_change;
        logic         sim_last;
        logic [127:0] mosi;
        logic [63:0]  tx;
        logic [1:0]   kind;
    } vec_t;

    typedef struct {
        logic [1:0]  kind;
        logic [63:0] rx;
        logic [15:0] cnt;
    } sb_t;

    logic clk = 1'b0;
    logic reset_global = 1'b1;
    always #5 clk = ~clk;

    spi_link_slave_mc_if #(.N_CH(2), .W(32)) bus ();

    spi_link_slave_mc #(.N_CH(2), .W(32), .SYNC(3)) dut (
        .clk          (clk),
        .reset_global (reset_global),
        .bus          (bus)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          pulses = 0;
    int          busy_cycles = 0;
    logic        chk_next = 1'b0;
    sb_t         cur;
    sb_t         sb_q[$];
    logic [63:0] m_rx = '0;
    logic [15:0] m_cnt = '0;
    vec_t        vecs[8];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // pulse monitor: pops the scoreboard on each result pulse and checks the committed state one cycle later
    initial forever begin
        @(negedge clk);
        if (chk_next) begin
            chk("sb_rx_data", 128'(bus.rx_data), 128'(cur.rx));
            chk("sb_frame_cnt", 128'(bus.frame_cnt), 128'(cur.cnt));
            chk_next = 1'b0;
        end
        if (bus.busy) busy_cycles++;
        if (bus.rx_valid || bus.frame_err) begin
            pulses++;
            chk("pulse_exclusive", 128'(bus.rx_valid & bus.frame_err), 128'(0));
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_pulse: got valid=%b err=%b expected no pulse", bus.rx_valid, bus.frame_err);
            end else begin
                cur = sb_q.pop_front();
                chk("sb_kind", 128'({bus.rx_valid, bus.frame_err}), 128'(cur.kind));
                chk_next = 1'b1;
            end
        end
    end

    task automatic run_frame(input vec_t v);
        logic [127:0] got_miso;
        logic [127:0] exp_miso;
        logic [127:0] ones;
        sb_t          e;
        int           nb;
        got_miso = '0;
        ones = '1;
        nb = (v.rst_at != 0) ? v.rst_at : v.nbits;
        exp_miso = v.en ? ({v.tx[31:0], v.tx[63:32], 64'b0} & ~(ones >> nb)) : '0;
        if (v.kind == 2'b10) begin
            m_rx = {v.mosi[95:64], v.mosi[127:96]};
            m_cnt = m_cnt + 16'd1;
        end
        if (v.kind != 2'b00) begin
            e.kind = v.kind;
            e.rx = m_rx;
            e.cnt = m_cnt;
            sb_q.push_back(e);
        end
        bus.tx_data = v.tx;
        bus.en = v.en;
        pulses = 0;
        busy_cycles = 0;
        wait_clk(1);
        bus.ssel = 1'b0;
        wait_clk(10);
        for (int i = 0; i < nb; i++) begin
            bus.mosi = v.mosi[127-i];
            if (v.mid_change && i == 10) begin
                bus.tx_data = ~v.tx;
                bus.en = 1'b0;
            end
            wait_clk(5);
            got_miso[127-i] = bus.miso;
            bus.sck = 1'b1;
            if (v.sim_last && i == nb - 1) bus.ssel = 1'b1;
            wait_clk(5);
            bus.sck = 1'b0;
        end
        if (v.rst_at != 0) begin
            reset_global = 1'b1;
            wait_clk(3);
            reset_global = 1'b0;
            m_rx = '0;
            m_cnt = '0;
        end
        wait_clk(5);
        bus.ssel = 1'b1;
        wait_clk(12);
        chk("pulse_count", 128'(pulses), 128'(v.kind != 2'b00));
        chk("sb_drained", 128'(sb_q.size()), 128'(0));
        chk("rx_data", 128'(bus.rx_data), 128'(m_rx));
        chk("frame_cnt", 128'(bus.frame_cnt), 128'(m_cnt));
        chk("miso_stream", got_miso, exp_miso);
        chk("busy_seen", 128'(busy_cycles != 0), 128'(v.en));
        chk("idle_busy", 128'(bus.busy), 128'(0));
    endtask

    initial begin
        vecs[0] = '{1'b1, 64, 0, 1'b0, 1'b0, {64'h42A00000_3F666666, 64'h0}, 64'h3F800000_41200000, 2'b10};
        vecs[1] = '{1'b1, 63, 0, 1'b0, 1'b0, {64'hDEADBEEF_12345678, 64'h0}, 64'h11112222_33334444, 2'b01};
        vecs[2] = '{1'b1, 65, 0, 1'b0, 1'b0, {64'hCAFEBABE_0BADF00D, 64'h8000000000000000}, 64'h0F0F0F0F_F0F0F0F0, 2'b01};
        vecs[3] = '{1'b0, 64, 0, 1'b0, 1'b0, {64'h42A00000_3F666666, 64'h0}, 64'hFFFFFFFF_FFFFFFFF, 2'b00};
        vecs[4] = '{1'b1, 64, 20, 1'b0, 1'b0, {64'h13579BDF_2468ACE0, 64'h0}, 64'hA5A5A5A5_5A5A5A5A, 2'b00};
        vecs[5] = '{1'b1, 64, 0, 1'b0, 1'b0, {64'hA5A5F00F_0123CDEF, 64'h0}, 64'h55AA33CC_80000001, 2'b10};
        vecs[6] = '{1'b1, 64, 0, 1'b1, 1'b0, {64'hFFFFFFFF_00000000, 64'h0}, 64'h12345678_9ABCDEF0, 2'b10};
        vecs[7] = '{1'b1, 64, 0, 1'b0, 1'b1, {64'h00000001_80000000, 64'h0}, 64'hFFFF0000_0000FFFF, 2'b10};

        bus.en = 1'b0;
        bus.sck = 1'b0;
        bus.ssel = 1'b1;
        bus.mosi = 1'b0;
        bus.tx_data = '0;
        wait_clk(3);
        reset_global = 1'b0;
        wait_clk(3);
        chk("reset_rx_data", 128'(bus.rx_data), 128'(0));
        chk("reset_frame_cnt", 128'(bus.frame_cnt), 128'(0));
        chk("reset_busy", 128'(bus.busy), 128'(0));
        chk("reset_miso", 128'(bus.miso), 128'(0));
        chk("reset_rx_valid", 128'(bus.rx_valid), 128'(0));
        chk("reset_frame_err", 128'(bus.frame_err), 128'(0));

        for (int i = 0; i < 8; i++) run_frame(vecs[i]);

        // counter wrap: preload the count as if 65535 good frames had passed, then one more good frame
        @(negedge clk);
        dut.frame_cnt_q = 16'hFFFF;
        m_cnt = 16'hFFFF;
        wait_clk(2);
        chk("preload_frame_cnt", 128'(bus.frame_cnt), 128'(16'hFFFF));
        run_frame(vecs[0]);
        chk("wrap_frame_cnt", 128'(bus.frame_cnt), 128'(16'h0000));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/spi_link_slave_mc.md
SPI_LINK_SLAVE_MC -- requirements
Module: spi_link_slave_mc

Interface
REQ-001 Parameter N_CH, default 2, number of W-bit channels per frame (1..8).
REQ-002 Parameter W, default 32, channel word width in bits (8..32).
REQ-003 Parameter SYNC, default 3, synchroniser depth on sck/ssel/mosi (>=2).
REQ-004 clk  input  1  system clock; SPI pins are oversampled, sck frequency SHALL be <= clk/8.
REQ-005 reset_global  input  1  reset, asynchronous, active-high.
REQ-006 en  input  1  frame enable; sampled at frame start.
REQ-007 sck  input  1  SPI clock, mode 0 (idle low, sample on rising, shift on falling).
REQ-008 ssel  input  1  SPI select, active-low, frames one transfer.
REQ-009 mosi  input  1  serial data from master, MSB first.
REQ-010 miso  output  1  serial data to master, MSB first.
REQ-011 tx_data  input  N_CH*W  words to return; channel k at [k*W +: W].
REQ-012 rx_data  output  N_CH*W  last good received frame; channel k at [k*W +: W].
REQ-013 rx_valid  output  1  one-cycle pulse, rx_data updated.
REQ-014 frame_err  output  1  one-cycle pulse, frame discarded.
REQ-015 busy  output  1  high while a frame is in progress.
REQ-016 frame_cnt  output  16  count of good frames, wraps 0xFFFF->0x0000.

Function
REQ-017 sck, ssel, mosi SHALL pass SYNC flip-flop stages on clk; edges SHALL be detected from the last two stages only.
REQ-018 FSM states SHALL be IDLE, SHIFT, CHECK; encoding free.
REQ-019 IDLE->SHIFT on detected ssel falling edge when en=1: tx shadow <= tx_data, bit_cnt <= 0, ovf <= 0, busy <= 1.
REQ-020 ssel falling edge with en=0 SHALL be ignored; FSM stays IDLE until the next falling edge, miso stays 0.
REQ-021 Transmission order SHALL be channel 0 first, then 1..N_CH-1, each MSB first.
REQ-022 In SHIFT, on each sck rising edge: sample mosi into rx shadow at bit position per REQ-021, bit_cnt <= bit_cnt+1.
REQ-023 In SHIFT, on each sck falling edge: advance tx shadow so miso presents the next bit; the first bit (channel 0 MSB) SHALL be on miso from the cycle after the ssel edge.
REQ-024 Rising edge with bit_cnt = N_CH*W SHALL set ovf and not modify the rx shadow; bit_cnt saturates.
REQ-025 SHIFT->CHECK on detected ssel rising edge (cycle t); CHECK lasts exactly one cycle (t+1), then IDLE.
REQ-026 In CHECK, if bit_cnt = N_CH*W and ovf = 0: rx_data <= rx shadow, rx_valid = 1, frame_cnt += 1.
REQ-027 Otherwise in CHECK: frame_err = 1, rx_data and frame_cnt unchanged.
REQ-028 rx_valid and frame_err SHALL never be high in the same cycle and SHALL each be high for exactly one cycle per frame.
REQ-029 busy SHALL be high in SHIFT and CHECK, low in IDLE.
REQ-030 miso SHALL be 0 in IDLE and CHECK.
REQ-031 tx_data changes during SHIFT SHALL NOT affect the frame in progress.
REQ-032 en deasserted during SHIFT SHALL NOT abort the frame.
REQ-033 Simultaneous ssel rising and sck rising detection: the sck sample SHALL be taken before the CHECK decision (counted in bit_cnt).

Reset
REQ-034 reset_global SHALL force IDLE, rx_data=0, rx_valid=0, frame_err=0, busy=0, miso=0, frame_cnt=0, bit_cnt=0, ovf=0, shadows=0.
REQ-035 Reset mid-frame SHALL discard the frame with no rx_valid/frame_err pulse; the next valid ssel falling edge after release starts a fresh frame.

Verification (N_CH=2, W=32, sck=clk/10)
REQ-036 tx_data={32'h3F80_0000,32'h4120_0000}, master sends 64 bits 0x42A00000 then 0x3F666666 -> rx_data[31:0]=0x42A00000, rx_data[63:32]=0x3F666666, one rx_valid, frame_cnt=1, miso stream = 0x41200000 then 0x3F800000.
REQ-037 Master sends 63 bits -> one frame_err, rx_data keeps previous value, frame_cnt unchanged.
REQ-038 Master sends 65 bits -> frame_err, rx_data unchanged.
REQ-039 en=0 at ssel fall, 64 bits sent -> no pulses, busy=0 throughout, miso=0.
REQ-040 reset_global pulsed after 20 bits, then full 64-bit frame -> no pulse for aborted frame, one rx_valid for second, frame_cnt=1.
REQ-041 frame_cnt preloaded by 65535 good frames, one more good frame -> frame_cnt=0x0000, rx_valid=1.
